uart_rx_packer: RTL and testbench
=================================

Name: uart_rx_packer

Overview:
- Upstream receive stage of the MVM UART system; sits between the serial `rx` pin and the matrix-vector multiply core.
- Recovers 8N1 UART frames and packs N_WORDS consecutive words into one W_BUS-bit bus.
- Presents each bus on a valid/ready master stream.
- Double-buffered, so reception of the next bus continues while the MVM core stalls.

Parameters:
- CLOCKS_PER_PULSE, 4, clock cycles per UART bit; even, >=4.
- BITS_PER_WORD, 8, data bits per UART frame.
- W_BUS, 128, output bus width; must be a multiple of BITS_PER_WORD. N_WORDS = W_BUS/BITS_PER_WORD.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- rx  in  1  UART serial input; idle high.
- m_data  out  W_BUS  packed bus; word k occupies bits [k*BITS_PER_WORD +: BITS_PER_WORD]; word 0 is the first received.
- m_valid  out  1  m_data holds an unconsumed bus.
- m_ready  in  1  downstream accepts m_data when m_valid && m_ready at a rising clk edge.
- frame_err  out  1  one-cycle pulse when a stop bit samples 0.
- overrun  out  1  one-cycle pulse when a completed bus is dropped.

Behaviour:
- Reset values (rstn=0, asynchronous):
  - m_valid=0, m_data=0, frame_err=0, overrun=0.
  - FSM=IDLE, bit counter=0, word counter=0, pack buffer=0.
  - rx synchronizer flops=1.
- Reset mid-frame or mid-bus discards all partial data. After release, reception waits for a fresh falling edge.
- rx passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s.
- FSM states:
  - IDLE: rx_s==0 -> START; clock counter loaded for CLOCKS_PER_PULSE/2 cycles.
  - START: at counter expiry (mid start bit), rx_s==0 -> DATA with counter = CLOCKS_PER_PULSE. rx_s==1 -> IDLE (glitch rejected; no error).
  - DATA: sample rx_s every CLOCKS_PER_PULSE cycles, LSB first, into the word shift register. After BITS_PER_WORD samples -> STOP.
  - STOP: one CLOCKS_PER_PULSE later (mid stop bit):
    - rx_s==1 -> word accepted, go to IDLE immediately. This supports back-to-back frames with zero idle bits.
    - rx_s==0 -> frame_err pulse next cycle, word discarded, word counter unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1 -> IDLE.
- Packing:
  - An accepted word is written into the pack buffer at slot = word counter, and the word counter increments.
  - When the accepted word is slot N_WORDS-1, the bus is complete and the word counter wraps to 0.
- Output register, on bus complete (single cycle, registered):
  - m_valid==0: load m_data, m_valid=1 on the next edge.
  - m_valid==1 && m_ready==1 in the same cycle: old bus is consumed, new bus loads, m_valid stays 1. No bubble, no overrun.
  - m_valid==1 && m_ready==0: new bus dropped, m_data unchanged, overrun pulses for 1 cycle.
- Handshake:
  - m_valid && m_ready with no completion that cycle -> m_valid=0 next edge; m_data holds its last value.
  - m_valid, once set, never drops without a handshake.
  - m_data is stable while m_valid && !m_ready.
- Latency: m_valid rises 1 clk after the mid-stop-bit sample of the last word. That is about 2 + (BITS_PER_WORD+1.5)*CLOCKS_PER_PULSE clks after that word's start-bit falling edge on rx.
- Counter widths: $clog2(CLOCKS_PER_PULSE+1), $clog2(BITS_PER_WORD+1), $clog2(N_WORDS+1). No overflow at any legal parameter set.

Test Plan:
- Reset/idle:
  - Stimulus: hold rx=1 for 100 clks after reset.
  - Response: m_valid, frame_err and overrun remain 0; m_data=0.
- Basic pack:
  - Stimulus: send bytes 0x00..0x0F with random 1–20 clk gaps; m_ready=1.
  - Response: one m_valid pulse with m_data=128'h0F0E0D0C0B0A09080706050403020100.
- MVM vector:
  - Stimulus: send bytes 0A 0B 0C 0D 0C 06 07 05 0F 01 02 0B 07 05 03 01, back-to-back with no idle bits.
  - Response: m_data=128'h0103050 70B02010F050706 0C0D0C0B0A read as bytes 01,03,05,07,0B,02,01,0F,05,07,06,0C,0D,0C,0B,0A from MSB down to LSB; each byte is exactly that received word.
- Backpressure/overrun:
  - Stimulus: m_ready=0; send 32 bytes (bus A = 0x00..0x0F, then bus B = 0x10..0x1F), then 16 more (0x20..0x2F).
  - Response: A held with m_valid=1 and stable throughout; overrun=0 on B's completion only if m_ready rose before it, else a single overrun pulse with A still held. Set m_ready=1 to drain, then the 0x20..0x2F bus appears.
- Framing error:
  - Stimulus: send 0x55 with stop bit=0, then 16 good bytes 0xA0..0xAF.
  - Response: a single frame_err pulse; bus = 0xAF..0xA0 (bad byte excluded).
- Glitch/reset:
  - Stimulus: apply a rx low pulse of CLOCKS_PER_PULSE/2-1 clks → no word is received. Then send 5 bytes, assert rstn=0 for 3 clks, and send 16 bytes 0x30..0x3F.
  - Response: bus = 0x3F..0x30.

Source files
------------

// File: rtl/uart_rx_packer_if.sv
// Valid/ready stream carrying one packed UART bus beat.
// The master drives data/valid and the slave drives ready.
interface uart_rx_packer_if #(
  parameter int W_BUS = 128
) ();
  logic [W_BUS-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_packer.sv
// 8N1 UART receiver that packs N_WORDS words into one W_BUS-bit stream beat.
// The pack buffer and the output register form a double buffer.
module uart_rx_packer #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_BUS            = 128
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  uart_rx_packer_if.master m,
  output logic             frame_err,
  output logic             overrun
);
  localparam int N_WORDS = W_BUS / BITS_PER_WORD;
  localparam int CW      = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int BW      = $clog2(BITS_PER_WORD + 1);
  localparam int WW      = $clog2(N_WORDS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t                   state, state_next;
  logic                     rx_meta, rx_s;
  logic [CW-1:0]            clk_cnt, clk_cnt_next;
  logic [BW-1:0]            bit_cnt, bit_cnt_next;
  logic [WW-1:0]            word_cnt;
  logic [BITS_PER_WORD-1:0] shift_reg, shift_next;
  logic [W_BUS-1:0]         pack_buf, bus_full, data_q;
  logic                     valid_q, tick, word_ok, stop_bad, bus_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      clk_cnt   <= clk_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
    end
  end

  // The counter is loaded with N and the action fires on the cycle it reads 1,
  // so every sample lands N cycles after the load.
  assign tick = (clk_cnt == CW'(1));

  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    word_ok      = 1'b0;
    stop_bad     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next   = START;
          clk_cnt_next = CW'(CLOCKS_PER_PULSE / 2);
        end
      end
      START: begin
        if (tick) begin
          clk_cnt_next = CW'(CLOCKS_PER_PULSE);
          bit_cnt_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_next = clk_cnt - CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          shift_next   = {rx_s, shift_reg[BITS_PER_WORD-1:1]};
          bit_cnt_next = bit_cnt + BW'(1);
          clk_cnt_next = CW'(CLOCKS_PER_PULSE);
          if (bit_cnt == BW'(BITS_PER_WORD - 1)) state_next = STOP;
        end else begin
          clk_cnt_next = clk_cnt - CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          clk_cnt_next = '0;
          if (rx_s) begin
            word_ok    = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = WAIT_HIGH;
          end
        end else begin
          clk_cnt_next = clk_cnt - CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The completing word is merged combinationally so the output register can
  // load the full bus on the same edge that accepts the last word.
  always_comb begin
    bus_full = pack_buf;
    bus_full[W_BUS-1 -: BITS_PER_WORD] = shift_reg;
  end

  assign bus_done = word_ok && (word_cnt == WW'(N_WORDS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pack_buf <= '0;
      word_cnt <= '0;
    end else if (word_ok) begin
      for (int k = 0; k < N_WORDS; k++) begin
        if (word_cnt == WW'(k)) pack_buf[k*BITS_PER_WORD +: BITS_PER_WORD] <= shift_reg;
      end
      word_cnt <= bus_done ? '0 : word_cnt + WW'(1);
    end
  end

  // A consumer handshake in the completion cycle frees the register, so the new
  // bus loads without a bubble; otherwise a pending bus blocks and drops it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= stop_bad;
      if (bus_done) begin
        if (!valid_q || m.ready) begin
          data_q  <= bus_full;
          valid_q <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid_q && m.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign m.data  = data_q;
  assign m.valid = valid_q;
endmodule

// File: tb/tb_uart_rx_packer.sv
// Scoreboard bench for uart_rx_packer: frames are driven on rx and expected buses
// are queued; a negedge monitor pops and compares on every handshake.
module tb_uart_rx_packer;
  localparam int CPP   = 4;
  localparam int BPW   = 8;
  localparam int W_BUS = 128;

  logic clk = 1'b0;
  logic rstn;
  logic rx;
  logic frame_err;
  logic overrun;

  int vectors     = 0;
  int miscompares = 0;
  int fe_cycles   = 0;
  int ov_cycles   = 0;
  logic [W_BUS-1:0] exp_q[$];

  uart_rx_packer_if #(.W_BUS(W_BUS)) bus_if ();

  uart_rx_packer #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD(BPW),
    .W_BUS(W_BUS)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rx(rx),
    .m(bus_if),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W_BUS-1:0] actual,
                             input logic [W_BUS-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one frame starting at a negedge: start bit, LSB-first data, stop, idle gap.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int gap);
    rx = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < BPW; i++) begin
      rx = b[i];
      repeat (CPP) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPP) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s: %0d buses still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (frame_err) fe_cycles++;
      if (overrun) ov_cycles++;
      if (bus_if.valid && bus_if.ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_bus", bus_if.data, '0);
        end else begin
          checkOutput("bus_data", bus_if.data, exp_q.pop_front());
        end
      end else if (bus_if.valid && exp_q.size() != 0) begin
        checkOutput("stall_stable", bus_if.data, exp_q[0]);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] mvm [16];
    mvm = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0C, 8'h06, 8'h07, 8'h05,
            8'h0F, 8'h01, 8'h02, 8'h0B, 8'h07, 8'h05, 8'h03, 8'h01};

    rstn = 1'b0;
    rx = 1'b1;
    bus_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", W_BUS'(bus_if.valid), '0);
    checkOutput("reset_data", bus_if.data, '0);
    checkOutput("reset_frame_err", W_BUS'(frame_err), '0);
    checkOutput("reset_overrun", W_BUS'(overrun), '0);
    rstn = 1'b1;

    repeat (100) @(negedge clk);
    checkOutput("idle_valid", W_BUS'(bus_if.valid), '0);
    checkOutput("idle_data", bus_if.data, '0);
    checkOutput("idle_frame_err_cycles", W_BUS'(fe_cycles), '0);
    checkOutput("idle_overrun_cycles", W_BUS'(ov_cycles), '0);

    exp_q.push_back(128'h0F0E0D0C0B0A09080706050403020100);
    for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b1, int'($urandom_range(1, 20)));
    waitDrain("basic_pack_drain");

    // A sub-half-bit low pulse must not start a word ahead of the vector.
    rx = 1'b0;
    repeat (CPP / 2 - 1) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    exp_q.push_back(128'h01030507_0B02010F_0507060C_0D0C0B0A);
    for (int i = 0; i < 16; i++) applyStimulus(mvm[i], 1'b1, 0);
    repeat (4) @(negedge clk);
    waitDrain("mvm_vector_drain");

    bus_if.ready = 1'b0;
    exp_q.push_back(128'h0F0E0D0C0B0A09080706050403020100);
    for (int i = 0; i < 32; i++) applyStimulus(8'(i), 1'b1, 1);
    repeat (4) @(negedge clk);
    checkOutput("stall_valid_held", W_BUS'(bus_if.valid), W_BUS'(1));
    checkOutput("overrun_cycles", W_BUS'(ov_cycles), W_BUS'(1));
    bus_if.ready = 1'b1;
    waitDrain("bus_a_drain");
    exp_q.push_back(128'h2F2E2D2C2B2A29282726252423222120);
    for (int i = 32; i < 48; i++) applyStimulus(8'(i), 1'b1, 1);
    waitDrain("bus_c_drain");
    checkOutput("overrun_after_drain", W_BUS'(ov_cycles), W_BUS'(1));

    applyStimulus(8'h55, 1'b0, 3);
    checkOutput("frame_err_cycles", W_BUS'(fe_cycles), W_BUS'(1));
    exp_q.push_back(128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    for (int i = 0; i < 16; i++) applyStimulus(8'hA0 + 8'(i), 1'b1, 2);
    waitDrain("frame_err_drain");

    for (int i = 0; i < 5; i++) applyStimulus(8'h90 + 8'(i), 1'b1, 1);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midbus_reset_valid", W_BUS'(bus_if.valid), '0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(128'h3F3E3D3C3B3A39383736353433323130);
    for (int i = 0; i < 16; i++) applyStimulus(8'h30 + 8'(i), 1'b1, 1);
    waitDrain("post_reset_drain");

    repeat (10) @(negedge clk);
    checkOutput("final_frame_err_cycles", W_BUS'(fe_cycles), W_BUS'(1));
    checkOutput("final_overrun_cycles", W_BUS'(ov_cycles), W_BUS'(1));
    checkOutput("final_valid", W_BUS'(bus_if.valid), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
